intersection_controller: RTL and testbench

Sequences a two-approach intersection (north-south and east-west) with latched pedestrian requests and vehicle-actuated early green termination. Each approach gets its own red/yellow/green outputs. An all-red clearance interval separates every direction change, and an optional all-red pedestrian walk phase can follow it. The block drives the lamp drivers directly and is the top-level sequencer for the traffic light subsystem.

---
 rtl/intersection_controller.sv | 152 +++++++++++++++
 tb/tb_intersection_controller.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/intersection_controller.sv
// Two-approach traffic light sequencer with all-red clearance, latched pedestrian
// walk phase and vehicle-actuated early termination of green.
module intersection_controller #(
    parameter int CNT_W       = 16,
    parameter int T_GREEN_MIN = 4,
    parameter int T_GREEN_MAX = 12,
    parameter int T_YELLOW    = 3,
    parameter int T_ALL_RED   = 2,
    parameter int T_WALK      = 5
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic ns_car_i,
    input  logic ew_car_i,
    input  logic ped_req_i,
    output logic ns_red_o,
    output logic ns_yellow_o,
    output logic ns_green_o,
    output logic ew_red_o,
    output logic ew_yellow_o,
    output logic ew_green_o,
    output logic walk_o,
    output logic ped_pending_o,
    output logic bad_state_o
);

    if (T_GREEN_MIN < 1 || T_GREEN_MIN > T_GREEN_MAX) begin : g_bad_green
        $error("intersection_controller: need 1 <= T_GREEN_MIN <= T_GREEN_MAX");
    end
    if (T_YELLOW < 1 || T_ALL_RED < 1 || T_WALK < 1) begin : g_bad_dur
        $error("intersection_controller: T_YELLOW, T_ALL_RED, T_WALK must be >= 1");
    end
    if ((64'(T_GREEN_MAX) >> CNT_W) != 0 || (64'(T_YELLOW) >> CNT_W) != 0 ||
        (64'(T_ALL_RED) >> CNT_W) != 0 || (64'(T_WALK) >> CNT_W) != 0) begin : g_bad_width
        $error("intersection_controller: a duration does not fit in CNT_W bits");
    end

    typedef enum logic [2:0] {
        ALL_RED   = 3'd0,
        NS_GREEN  = 3'd1,
        NS_YELLOW = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        PED_WALK  = 3'd5
    } state_t;

    localparam logic DIR_NS = 1'b0;
    localparam logic DIR_EW = 1'b1;

    localparam logic [CNT_W-1:0] LAST_ALL_RED   = CNT_W'(T_ALL_RED - 1);
    localparam logic [CNT_W-1:0] LAST_WALK      = CNT_W'(T_WALK - 1);
    localparam logic [CNT_W-1:0] LAST_YELLOW    = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] LAST_GREEN_MIN = CNT_W'(T_GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] LAST_GREEN_MAX = CNT_W'(T_GREEN_MAX - 1);

    // Held as a plain vector so that codes outside the enum can be represented and flagged.
    logic [2:0]       state_reg;
    logic [2:0]       state_next;
    logic             next_dir;
    logic             dir_next;
    logic [CNT_W-1:0] phase_cnt;
    logic             ped_pending;
    logic             ns_green_done;
    logic             ew_green_done;

    // Green may end early only once its minimum has elapsed and someone else is waiting.
    assign ns_green_done = (phase_cnt == LAST_GREEN_MAX) ||
                           ((phase_cnt >= LAST_GREEN_MIN) && (ew_car_i || ped_pending));
    assign ew_green_done = (phase_cnt == LAST_GREEN_MAX) ||
                           ((phase_cnt >= LAST_GREEN_MIN) && (ns_car_i || ped_pending));

    always_comb begin
        state_next = state_reg;
        dir_next   = next_dir;
        case (state_reg)
            ALL_RED: begin
                if (phase_cnt == LAST_ALL_RED) begin
                    if (ped_pending)
                        state_next = PED_WALK;
                    else
                        state_next = (next_dir == DIR_EW) ? EW_GREEN : NS_GREEN;
                end
            end
            PED_WALK: begin
                if (phase_cnt == LAST_WALK)
                    state_next = (next_dir == DIR_EW) ? EW_GREEN : NS_GREEN;
            end
            NS_GREEN: begin
                if (ns_green_done)
                    state_next = NS_YELLOW;
            end
            EW_GREEN: begin
                if (ew_green_done)
                    state_next = EW_YELLOW;
            end
            NS_YELLOW: begin
                if (phase_cnt == LAST_YELLOW) begin
                    state_next = ALL_RED;
                    dir_next   = DIR_EW;
                end
            end
            EW_YELLOW: begin
                if (phase_cnt == LAST_YELLOW) begin
                    state_next = ALL_RED;
                    dir_next   = DIR_NS;
                end
            end
            default: state_next = ALL_RED;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg   <= ALL_RED;
            next_dir    <= DIR_NS;
            phase_cnt   <= '0;
            ped_pending <= 1'b0;
        end else begin
            state_reg <= state_next;
            next_dir  <= dir_next;
            phase_cnt <= (state_next != state_reg) ? '0 : phase_cnt + CNT_W'(1);
            // Button presses during the walk, or on the edge that starts it, are already served.
            if (state_reg == PED_WALK || (state_reg == ALL_RED && state_next == PED_WALK))
                ped_pending <= 1'b0;
            else if (ped_req_i)
                ped_pending <= 1'b1;
        end
    end

    always_comb begin
        ns_red_o    = 1'b1;
        ns_yellow_o = 1'b0;
        ns_green_o  = 1'b0;
        ew_red_o    = 1'b1;
        ew_yellow_o = 1'b0;
        ew_green_o  = 1'b0;
        walk_o      = 1'b0;
        bad_state_o = 1'b0;
        case (state_reg)
            ALL_RED:   ;
            NS_GREEN:  begin ns_red_o = 1'b0; ns_green_o  = 1'b1; end
            NS_YELLOW: begin ns_red_o = 1'b0; ns_yellow_o = 1'b1; end
            EW_GREEN:  begin ew_red_o = 1'b0; ew_green_o  = 1'b1; end
            EW_YELLOW: begin ew_red_o = 1'b0; ew_yellow_o = 1'b1; end
            PED_WALK:  walk_o = 1'b1;
            default:   bad_state_o = 1'b1;
        endcase
    end

    assign ped_pending_o = ped_pending;

endmodule

// File: tb/tb_intersection_controller.sv
// Bench for intersection_controller: phase-length tables, hand-written pedestrian,
// reset and illegal-state sequences, and a randomized run against a phase model.
module tb_intersection_controller;

    localparam int T_GREEN_MIN = 4;
    localparam int T_GREEN_MAX = 12;
    localparam int T_YELLOW    = 3;
    localparam int T_ALL_RED   = 2;
    localparam int T_WALK      = 5;

    // Lamp vector order: ns red, ns yellow, ns green, ew red, ew yellow, ew green, walk.
    localparam logic [6:0] L_AR   = 7'b100_100_0;
    localparam logic [6:0] L_NSG  = 7'b001_100_0;
    localparam logic [6:0] L_NSY  = 7'b010_100_0;
    localparam logic [6:0] L_EWG  = 7'b100_001_0;
    localparam logic [6:0] L_EWY  = 7'b100_010_0;
    localparam logic [6:0] L_WALK = 7'b100_100_1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ns_car = 1'b0;
    logic ew_car = 1'b0;
    logic ped_req = 1'b0;
    logic ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk, ped_pending, bad_state;

    int n_tests = 0;
    int n_fail  = 0;

    intersection_controller #(
        .CNT_W(16), .T_GREEN_MIN(T_GREEN_MIN), .T_GREEN_MAX(T_GREEN_MAX),
        .T_YELLOW(T_YELLOW), .T_ALL_RED(T_ALL_RED), .T_WALK(T_WALK)
    ) dut (
        .clk_i(clk), .rst_i(rst), .ns_car_i(ns_car), .ew_car_i(ew_car), .ped_req_i(ped_req),
        .ns_red_o(ns_red), .ns_yellow_o(ns_yellow), .ns_green_o(ns_green),
        .ew_red_o(ew_red), .ew_yellow_o(ew_yellow), .ew_green_o(ew_green),
        .walk_o(walk), .ped_pending_o(ped_pending), .bad_state_o(bad_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         do_rst;
        bit         ns_car;
        bit         ew_car;
        bit         ped;
        logic [6:0] lamps;
        bit         pend;
        int         cycles;
        string      name;
    } seg_t;

    seg_t tbl[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic check(input string name, input logic [6:0] exp_l, input bit exp_p, input bit exp_b);
        logic [6:0] got;
        got = {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk};
        n_tests++;
        if (got !== exp_l || ped_pending !== exp_p || bad_state !== exp_b) begin
            n_fail++;
            $display("FAIL %s @%0t: got lamps=%b ped=%b bad=%b, required lamps=%b ped=%b bad=%b",
                     name, $time, got, ped_pending, bad_state, exp_l, exp_p, exp_b);
        end
    endtask

    task automatic seg(input string name, input logic [6:0] lamps, input bit pend, input int n);
        for (int i = 0; i < n; i++) begin
            check(name, lamps, pend, 1'b0);
            tick();
        end
    endtask

    // Reference model: phase names 0 clear, 1 ns go, 2 ns amber, 3 ew go, 4 ew amber, 5 walk.
    int m_ph, m_el;
    bit m_ew_next, m_ped;

    function automatic logic [6:0] lamps_of(input int ph);
        case (ph)
            1:       return L_NSG;
            2:       return L_NSY;
            3:       return L_EWG;
            4:       return L_EWY;
            5:       return L_WALK;
            default: return L_AR;
        endcase
    endfunction

    task automatic model_step(input bit r, input bit nsc, input bit ewc, input bit pq);
        int nph;
        bit nped;
        if (r) begin
            m_ph = 0; m_el = 0; m_ew_next = 0; m_ped = 0;
            return;
        end
        nph  = m_ph;
        nped = m_ped || (pq && m_ph != 5);
        case (m_ph)
            0: if (m_el == T_ALL_RED - 1) begin
                   if (m_ped) begin nph = 5; nped = 0; end
                   else nph = m_ew_next ? 3 : 1;
               end
            5: if (m_el == T_WALK - 1) nph = m_ew_next ? 3 : 1;
            1: if (m_el == T_GREEN_MAX - 1 || (m_el >= T_GREEN_MIN - 1 && (ewc || m_ped))) nph = 2;
            3: if (m_el == T_GREEN_MAX - 1 || (m_el >= T_GREEN_MIN - 1 && (nsc || m_ped))) nph = 4;
            2: if (m_el == T_YELLOW - 1) begin nph = 0; m_ew_next = 1; end
            4: if (m_el == T_YELLOW - 1) begin nph = 0; m_ew_next = 0; end
            default: nph = 0;
        endcase
        m_el  = (nph != m_ph) ? 0 : m_el + 1;
        m_ph  = nph;
        m_ped = nped;
    endtask

    initial begin
        // Free-running sequence with no demand, then with EW demand held from reset.
        tbl.push_back('{1, 0, 0, 0, L_AR,  0,  2, "idle_ar"});
        tbl.push_back('{0, 0, 0, 0, L_NSG, 0, 12, "idle_nsg"});
        tbl.push_back('{0, 0, 0, 0, L_NSY, 0,  3, "idle_nsy"});
        tbl.push_back('{0, 0, 0, 0, L_AR,  0,  2, "idle_ar2"});
        tbl.push_back('{0, 0, 0, 0, L_EWG, 0, 12, "idle_ewg"});
        tbl.push_back('{0, 0, 0, 0, L_EWY, 0,  3, "idle_ewy"});
        tbl.push_back('{0, 0, 0, 0, L_AR,  0,  2, "idle_ar3"});
        tbl.push_back('{0, 0, 0, 0, L_NSG, 0,  1, "idle_wrap"});
        tbl.push_back('{1, 0, 1, 0, L_AR,  0,  2, "ewcar_ar"});
        tbl.push_back('{0, 0, 1, 0, L_NSG, 0,  4, "ewcar_nsg"});
        tbl.push_back('{0, 0, 1, 0, L_NSY, 0,  3, "ewcar_nsy"});
        tbl.push_back('{0, 0, 1, 0, L_AR,  0,  2, "ewcar_ar2"});
        tbl.push_back('{0, 0, 1, 0, L_EWG, 0, 12, "ewcar_ewg"});
        tbl.push_back('{0, 0, 1, 0, L_EWY, 0,  3, "ewcar_ewy"});
        tbl.push_back('{0, 0, 1, 0, L_AR,  0,  2, "ewcar_ar3"});
        tbl.push_back('{0, 0, 1, 0, L_NSG, 0,  4, "ewcar_nsg2"});

        do_reset();
        check("reset", L_AR, 1'b0, 1'b0);

        foreach (tbl[k]) begin
            ns_car  = tbl[k].ns_car;
            ew_car  = tbl[k].ew_car;
            ped_req = tbl[k].ped;
            if (tbl[k].do_rst) do_reset();
            seg(tbl[k].name, tbl[k].lamps, tbl[k].pend, tbl[k].cycles);
        end
        ns_car = 0; ew_car = 0; ped_req = 0;

        // Single pedestrian pulse during NS green.
        do_reset();
        seg("pp_ar", L_AR, 0, 2);
        seg("pp_nsg0", L_NSG, 0, 1);
        ped_req = 1;
        seg("pp_nsg1", L_NSG, 0, 1);
        ped_req = 0;
        seg("pp_nsg_pend", L_NSG, 1, 2);
        seg("pp_nsy", L_NSY, 1, 3);
        seg("pp_ar2", L_AR, 1, 2);
        seg("pp_walk", L_WALK, 0, 5);
        seg("pp_ewg", L_EWG, 0, 12);
        seg("pp_ewy", L_EWY, 0, 3);

        // Pedestrian button held: a walk after every clearance, greens cut to minimum.
        ped_req = 1;
        do_reset();
        seg("ph_ar0", L_AR, 0, 1);
        seg("ph_ar1", L_AR, 1, 1);
        seg("ph_walk1", L_WALK, 0, 5);
        seg("ph_nsg0", L_NSG, 0, 1);
        seg("ph_nsg", L_NSG, 1, 3);
        seg("ph_nsy", L_NSY, 1, 3);
        seg("ph_ar2", L_AR, 1, 2);
        seg("ph_walk2", L_WALK, 0, 5);
        seg("ph_ewg0", L_EWG, 0, 1);
        seg("ph_ewg", L_EWG, 1, 3);
        seg("ph_ewy", L_EWY, 1, 3);
        seg("ph_ar3", L_AR, 1, 2);
        seg("ph_walk3", L_WALK, 0, 5);
        ped_req = 0;

        // Reset mid EW green with a pending pedestrian request.
        do_reset();
        seg("mr_ar", L_AR, 0, 2);
        seg("mr_nsg", L_NSG, 0, 12);
        seg("mr_nsy", L_NSY, 0, 3);
        seg("mr_ar2", L_AR, 0, 2);
        seg("mr_ewg0", L_EWG, 0, 1);
        ped_req = 1;
        seg("mr_ewg1", L_EWG, 0, 1);
        ped_req = 0;
        check("mr_ewg_pend", L_EWG, 1, 0);
        do_reset();
        seg("mr_after_rst", L_AR, 0, 2);
        seg("mr_nsg_again", L_NSG, 0, 1);

        // Illegal state code: all red, flagged, then back to clearance.
        do_reset();
        force dut.state_reg = 3'd7;
        #1;
        check("bad_state", L_AR, 0, 1);
        release dut.state_reg;
        tick();
        check("bad_recover", L_AR, 0, 0);

        // Randomized demand against the phase model.
        do_reset();
        model_step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 3000; c++) begin
            bit r;
            r       = ($urandom_range(0, 199) == 0);
            ns_car  = ($urandom_range(0, 3) == 0);
            ew_car  = ($urandom_range(0, 3) == 0);
            ped_req = ($urandom_range(0, 15) == 0);
            rst     = r;
            check("rand", lamps_of(m_ph), m_ped, 1'b0);
            tick();
            model_step(r, ns_car, ew_car, ped_req);
        end
        rst = 0;
        check("rand_end", lamps_of(m_ph), m_ped, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
